// File: rtl/calc_queue_if.sv
// Command/status bundle between the ALU and the operand queue.
// The master issues queue commands; the slave executes them and reports state.
interface calc_queue_if #(
  parameter int AW = 4
);
  logic          op_valid;
  logic [1:0]    queue_op;
  logic [7:0]    push_data;
  logic [15:0]   operands;
  logic [7:0]    pop_data;
  logic          pop_valid;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          sync;
  logic          overflow;
  logic          underflow;

  modport master (
    output op_valid, queue_op, push_data,
    input  operands, pop_data, pop_valid, count, empty, full, sync, overflow, underflow
  );

  modport slave (
    input  op_valid, queue_op, push_data,
    output operands, pop_data, pop_valid, count, empty, full, sync, overflow, underflow
  );
endinterface

// File: rtl/calc_queue.sv
// Circular operand queue closing the ALU compute loop: executes one command per
// cycle and feeds the two oldest entries back to the ALU as operands.
module calc_queue #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  calc_queue_if.slave q
);

  localparam logic [1:0] Q_PUSH         = 2'b00;
  localparam logic [1:0] Q_SLEEP        = 2'b01;
  localparam logic [1:0] Q_GET_AND_PUSH = 2'b10;
  localparam logic [1:0] Q_POP          = 2'b11;

  localparam logic [AW:0] C_ONE  = (AW+1)'(1);
  localparam logic [AW:0] C_TWO  = (AW+1)'(2);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic [7:0]    r_pop_data;
  logic          r_pop_valid;
  logic          r_sync;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_full;
  logic          w_is_push;
  logic          w_is_pop;
  logic          w_is_gap;
  logic          w_push_ok;
  logic          w_pop_ok;
  logic          w_gap_ok;
  logic          w_write;
  logic [AW-1:0] w_head_p1;

  assign w_full    = (r_count == C_FULL);
  assign w_is_push = q.op_valid && (q.queue_op == Q_PUSH);
  assign w_is_pop  = q.op_valid && (q.queue_op == Q_POP);
  assign w_is_gap  = q.op_valid && (q.queue_op == Q_GET_AND_PUSH);
  assign w_push_ok = w_is_push && !w_full;
  assign w_pop_ok  = w_is_pop && (r_count >= C_ONE);
  assign w_gap_ok  = w_is_gap && (r_count >= C_TWO);
  assign w_write   = w_push_ok || w_gap_ok;
  assign w_head_p1 = r_head + AW'(1);

  // Storage is deliberately unreset; count gating keeps X off the outputs.
  always_ff @(posedge clk) begin
    if (w_write) begin
      r_mem[r_tail] <= q.push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_pop_data  <= '0;
      r_pop_valid <= 1'b0;
      r_sync      <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_sync      <= q.op_valid;
      r_pop_valid <= w_pop_ok;
      if (w_pop_ok) begin
        r_pop_data <= r_mem[r_head];
      end
      if (w_write) begin
        r_tail <= r_tail + AW'(1);
      end
      if (w_pop_ok) begin
        r_head <= w_head_p1;
      end else if (w_gap_ok) begin
        r_head <= r_head + AW'(2);
      end
      // Get-and-push frees two and writes one, so it nets -1 like a pop.
      if (w_push_ok) begin
        r_count <= r_count + C_ONE;
      end else if (w_pop_ok || w_gap_ok) begin
        r_count <= r_count - C_ONE;
      end
      if (w_is_push && w_full) begin
        r_overflow <= 1'b1;
      end
      if ((w_is_pop && !w_pop_ok) || (w_is_gap && !w_gap_ok)) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign q.operands[7:0]  = (r_count >= C_ONE) ? r_mem[r_head]    : 8'h00;
  assign q.operands[15:8] = (r_count >= C_TWO) ? r_mem[w_head_p1] : 8'h00;
  assign q.pop_data       = r_pop_data;
  assign q.pop_valid      = r_pop_valid;
  assign q.count          = r_count;
  assign q.empty          = (r_count == '0);
  assign q.full           = w_full;
  assign q.sync           = r_sync;
  assign q.overflow       = r_overflow;
  assign q.underflow      = r_underflow;

  logic w_unused;
  assign w_unused = (q.queue_op == Q_SLEEP);

endmodule

// File: doc/calc_queue.md
# calc_queue

Operand queue for the queue calculator, directly downstream of the combinational ALU. Each cycle it executes the ALU's `queue_op` command (push, pop, get-and-push, sleep) using the ALU `result` as write data. It presents the two oldest entries back to the ALU as `operands`, closing the compute loop. It also reports occupancy, popped data, a per-command acknowledge and sticky error flags.

## Interface
- `DEPTH`, 16, number of 8-bit entries; power of two, ≥ 4
- `AW`, 4, log2(DEPTH); pointer width
- `Q_PUSH`, 2'b00, push `push_data` at tail
- `Q_SLEEP`, 2'b01, no operation
- `Q_POP`, 2'b11, remove head, emit it on `pop_data`
- `Q_GET_AND_PUSH`, 2'b10, remove two oldest entries, push `push_data`

Ports:
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  asynchronous, active-low reset
- `op_valid`  input  1  `queue_op` is executed at this edge
- `queue_op`  input  2  command from ALU
- `push_data`  input  8  ALU `result`
- `operands`  output  16  {entry[head+1], entry[head]}, to ALU
- `pop_data`  output  8  value removed by last accepted `Q_POP`
- `pop_valid`  output  1  one-cycle strobe with `pop_data`
- `count`  output  AW+1  occupancy, 0..DEPTH
- `empty`  output  1  count == 0
- `full`  output  1  count == DEPTH
- `sync`  output  1  one-cycle acknowledge per `op_valid` cycle
- `overflow`  output  1  sticky: push rejected while full
- `underflow`  output  1  sticky: pop/get-and-push rejected for too few entries

## Operation
- Circular buffer: `head` (oldest), `tail` (next write); both are AW-bit pointers and wrap modulo DEPTH; `count` is held as a separate register.
- `Q_PUSH`: if !full, entry[tail]=push_data, tail+1, count+1; else set `overflow`, no state change.
- `Q_POP`: if count≥1, pop_data=entry[head], pop_valid=1, head+1, count-1; else set `underflow`, no state change.
- `Q_GET_AND_PUSH`: requires count≥2.
  - When accepted: head+2; entry[tail]=push_data; tail+1; count-1 net.
  - It never overflows, because two entries free before one is written.
  - If count<2: set `underflow`, no state change, no write.
- `Q_SLEEP` or `op_valid`=0: no state change.
- `operands[7:0]` = entry[head] if count≥1, else 0.
- `operands[15:8]` = entry[(head+1) mod DEPTH] if count≥2, else 0.
- `operands` is combinational from registered state only (no input→output path), so the ALU loop has no combinational cycle. The ALU uses [7:0] as the first operand (e.g. SUB = [7:0]−[15:8]).
- `sync` pulses for every `op_valid` cycle, including rejected and sleep commands.
- `overflow`/`underflow` stay set until reset and do not block later valid commands.
- Storage array is not reset; count gating guarantees no X on `operands`.

## Timing
- Reset (`rst`=0, asynchronous, any time including mid-command) has immediate effect:
  - head=tail=count=0, empty=1, full=0
  - operands=0, pop_data=0, pop_valid=0, sync=0, overflow=underflow=0
  - Release is synchronous to `clk`; the first command is accepted at the first rising edge with `rst`=1.
- A command sampled at edge N updates head/tail/count/flags at edge N.
- `sync`, `pop_valid` and `pop_data` are registered: high during cycle N→N+1 only.
- `operands`, `count`, `empty` and `full` reflect the updated state just after edge N. The ALU result for the next command is therefore valid before edge N+1, giving a throughput of one command per cycle.
- `pop_data` holds its last value when `pop_valid`=0.
- Pointer wrap: at head=DEPTH-1, operands[15:8] reads entry[0]; a get-and-push at head=DEPTH-2 sets head=0.

## Test plan
- Reset: drive `rst`=0 mid-stream with count=5 → count=0, empty=1, operands=16'h0000, flags=0 immediately, without waiting for a clock edge.
- Compute loop: push 8'd5, push 8'd3 → operands=16'h0305; get-and-push with push_data=8'd8 → count=1, operands=16'h0008, sync pulse per command.
- Full/overflow: push 0..15 (DEPTH=16) → full=1, count=16; 17th push 8'hAA → overflow=1, count=16, sync=1, next pops return 0,1,2…
- Underflow: pop on empty → underflow=1, pop_valid=0, count=0; push 8'd7, then get-and-push → underflow stays 1, count=1, operands=16'h0007.
- Wrap-around: push 16 values 0x10..0x1F, pop 15 (pop_data 0x10..0x1E), push 0x20 → head=15, operands=16'h201F; get-and-push 0x30 → count=1, operands=16'h0030.
- Sleep/idle: `op_valid`=0 with any `queue_op` → no change, sync=0; `op_valid`=1 with Q_SLEEP → no change, sync=1.
